// File: rtl/dual_rail_result_checker.sv
// rtl/dual_rail_result_checker.sv - compares duplicated X/Y result rails, registers checked results, tracks faults
module dual_rail_result_checker #(
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           x_sum,
  input  logic                 x_carry,
  input  logic [1:0]           x_err,
  input  logic [2:0]           y_sum,
  input  logic                 y_carry,
  input  logic [1:0]           y_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           res_sum,
  output logic                 res_carry,
  output logic [1:0]           res_err,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clear_fault
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam logic [3:0]           THRESH  = 4'(FAULT_THRESH);
  localparam logic [1:0]           ERR_OK  = 2'b10;
  localparam logic [1:0]           ERR_BAD = 2'b11;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t               state, state_nxt;
  logic [3:0]           consec, consec_nxt, consec_inc;
  logic [ERR_CNT_W-1:0] err_cnt, err_cnt_nxt;
  logic                 accept, code_ok, mismatch, bad;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign code_ok    = (x_err == ERR_OK) && (y_err == ERR_OK);
  assign mismatch   = ({x_carry, x_sum} != {y_carry, y_sum});
  assign bad        = mismatch || !code_ok;
  assign consec_inc = consec + 4'd1;
  assign err_count  = err_cnt;

  // A clear wins over a coincident accepted sample: the sample is registered but not scored.
  always_comb begin
    state_nxt   = state;
    consec_nxt  = consec;
    err_cnt_nxt = err_cnt;
    if (clear_fault) begin
      state_nxt   = ST_OK;
      consec_nxt  = 4'd0;
      err_cnt_nxt = '0;
    end else if (accept && bad) begin
      if (err_cnt != CNT_MAX) begin
        err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
      end
      case (state)
        ST_OK: begin
          consec_nxt = 4'd1;
          state_nxt  = (THRESH <= 4'd1) ? ST_FAULT : ST_SUSPECT;
        end
        ST_SUSPECT: begin
          consec_nxt = consec_inc;
          if (consec_inc >= THRESH) begin
            state_nxt = ST_FAULT;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
    end else if (accept && state == ST_SUSPECT) begin
      state_nxt  = ST_OK;
      consec_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OK;
      consec  <= 4'd0;
      err_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      consec  <= consec_nxt;
      err_cnt <= err_cnt_nxt;
      fault   <= (state_nxt == ST_FAULT);
    end
  end

  // Result register: refilled on accept, emptied only when drained with nothing new arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_sum   <= 3'd0;
      res_carry <= 1'b0;
      res_err   <= ERR_OK;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_sum   <= x_sum;
      res_carry <= x_carry;
      res_err   <= (bad || state == ST_FAULT) ? ERR_BAD : ERR_OK;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_rail_result_checker.sv
// tb/tb_dual_rail_result_checker.sv - directed scoreboard bench for dual_rail_result_checker
module tb_dual_rail_result_checker;

  localparam int THRESH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clear_fault;
  logic [2:0] x_sum, y_sum;
  logic       x_carry, y_carry;
  logic [1:0] x_err, y_err;

  logic       in_ready, out_valid, res_carry, fault;
  logic [2:0] res_sum;
  logic [1:0] res_err;
  logic [7:0] err_count;

  logic       u2_in_ready, u2_out_valid, u2_res_carry, u2_fault;
  logic [2:0] u2_res_sum;
  logic [1:0] u2_res_err, u2_err_count;

  dual_rail_result_checker #(.ERR_CNT_W(8), .FAULT_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_sum(x_sum), .x_carry(x_carry), .x_err(x_err),
    .y_sum(y_sum), .y_carry(y_carry), .y_err(y_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_err(res_err),
    .fault(fault), .err_count(err_count), .clear_fault(clear_fault)
  );

  dual_rail_result_checker #(.ERR_CNT_W(2), .FAULT_THRESH(THRESH)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready),
    .x_sum(x_sum), .x_carry(x_carry), .x_err(x_err),
    .y_sum(y_sum), .y_carry(y_carry), .y_err(y_err),
    .out_valid(u2_out_valid), .out_ready(out_ready),
    .res_sum(u2_res_sum), .res_carry(u2_res_carry), .res_err(u2_res_err),
    .fault(u2_fault), .err_count(u2_err_count), .clear_fault(clear_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] sb_q[$];
  logic       m_ov;
  int         m_state;
  int         m_consec;
  int         m_cnt;
  int         m_cnt2;
  int         stall_left;
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ov = 1'b0; m_state = 0; m_consec = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock: inputs already driven; judge handshake mid-cycle, then check state after the edge.
  task automatic cycle();
    logic       acc, bad, held_v;
    logic [5:0] held, exp_r;
    out_ready = (stall_left == 0);
    #3;
    chk("in_ready", in_ready, !m_ov || out_ready);
    acc = in_valid && (!m_ov || out_ready);
    held_v = m_ov && !out_ready;
    held = {res_sum, res_carry, res_err};
    if (m_ov && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_r = sb_q.pop_front();
        chk("result", {res_sum, res_carry, res_err}, exp_r);
      end
    end
    bad = ({x_carry, x_sum} != {y_carry, y_sum}) || (x_err != 2'b10) || (y_err != 2'b10);
    if (acc) sb_q.push_back({x_sum, x_carry, (bad || m_state == 2) ? 2'b11 : 2'b10});
    if (clear_fault) begin
      m_state = 0; m_consec = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (acc && bad) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_state != 2) begin
        m_consec++;
        m_state = (m_consec >= THRESH) ? 2 : 1;
      end
    end else if (acc && m_state == 1) begin
      m_state = 0; m_consec = 0;
    end
    m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    last_acc = acc;
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("fault", fault, m_state == 2);
    chk("err_count", err_count, m_cnt);
    chk("u2_err_count", u2_err_count, m_cnt2);
    if (held_v) chk("res_stable", {res_sum, res_carry, res_err}, held);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic send(input logic [2:0] xs, input logic xc, input logic [1:0] xe,
                      input logic [2:0] ys, input logic yc, input logic [1:0] ye);
    int n;
    x_sum = xs; x_carry = xc; x_err = xe;
    y_sum = ys; y_carry = yc; y_err = ye;
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    clear_fault = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cycle();
    clear_fault = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_fault = 1'b0;
    x_sum = 3'd0; x_carry = 1'b0; x_err = 2'b10;
    y_sum = 3'd0; y_carry = 1'b0; y_err = 2'b10;
    stall_left = 0; last_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_carry", res_carry, 0);
    chk("rst_res_err", res_err, 2'b10);
    chk("rst_fault", fault, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // clean stream at full throughput
    for (int i = 0; i < 4; i++) send(3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10);
    chk("clean_res_sum", res_sum, 5);
    chk("clean_res_err", res_err, 2'b10);
    idle();

    // backpressure: downstream stalls 3 cycles
    stall_left = 3;
    send(3'd1, 1'b1, 2'b10, 3'd1, 1'b1, 2'b10);
    send(3'd2, 1'b0, 2'b10, 3'd2, 1'b0, 2'b10);
    send(3'd3, 1'b1, 2'b10, 3'd3, 1'b1, 2'b10);
    idle();
    chk("bp_drained", sb_q.size(), 0);

    // three distinct bad samples reach the fault threshold
    send(3'd3, 1'b0, 2'b10, 3'd2, 1'b0, 2'b10);
    chk("e1_count", err_count, 1);
    send(3'd4, 1'b0, 2'b01, 3'd4, 1'b0, 2'b10);
    chk("e2_count", err_count, 2);
    chk("e2_fault", fault, 0);
    send(3'd6, 1'b1, 2'b10, 3'd6, 1'b1, 2'b11);
    chk("e3_count", err_count, 3);
    chk("e3_fault", fault, 1);
    chk("e3_res_err", res_err, 2'b11);

    // clean sample while faulted still flagged; then clear with a bad sample
    send(3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10);
    chk("fault_clean_res_err", res_err, 2'b11);
    clear_fault = 1'b1;
    send(3'd7, 1'b0, 2'b11, 3'd7, 1'b0, 2'b11);
    chk("clr_fault", fault, 0);
    chk("clr_count", err_count, 0);
    chk("clr_res_err", res_err, 2'b11);

    // bad, bad, good, bad: FSM recovers before threshold
    send(3'd1, 1'b0, 2'b10, 3'd0, 1'b0, 2'b10);
    send(3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b10);
    send(3'd2, 1'b0, 2'b10, 3'd2, 1'b0, 2'b10);
    send(3'd3, 1'b1, 2'b10, 3'd3, 1'b0, 2'b10);
    chk("bbgb_fault", fault, 0);
    chk("bbgb_count", err_count, 3);

    // saturation of the narrow counter
    clear_fault = 1'b1;
    idle();
    for (int i = 0; i < 6; i++) send(3'(i), 1'b0, 2'b10, 3'(i + 1), 1'b0, 2'b10);
    chk("sat_u2_count", u2_err_count, 3);
    chk("sat_main_count", err_count, 6);

    // asynchronous reset with a result pending
    send(3'd4, 1'b0, 2'b10, 3'd4, 1'b0, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fault", fault, 0);
    chk("arst_count", err_count, 0);
    chk("arst_u2_count", u2_err_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(3'd6, 1'b0, 2'b10, 3'd6, 1'b0, 2'b10);
    idle();
    chk("final_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
